// File: rtl/rs_multi_cdb_pkg.sv
// rs_multi_cdb_pkg -- shared constants and the entry record for the ALU
// reservation station.
//   ROB_ID_W / DATA_W : tag and operand widths used by every file of the block
//   OPCODE_W / FUNC3_W: decoded instruction field widths
//   RS_SZ_DEF, RS_ID_W_DEF, CDB_N_DEF : default depth / index width / channels
//   rs_entry_t        : one waiting op (decoded fields, two operands, dest tag)
package rs_multi_cdb_pkg;

  localparam int ROB_ID_W    = 4;
  localparam int DATA_W      = 32;
  localparam int OPCODE_W    = 7;
  localparam int FUNC3_W     = 3;
  localparam int RS_SZ_DEF   = 8;
  localparam int RS_ID_W_DEF = 3;
  localparam int CDB_N_DEF   = 2;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FUNC3_W-1:0]  func3;
    logic                func1;
    logic                v1;
    logic                v2;
    logic [DATA_W-1:0]   d1;
    logic [DATA_W-1:0]   d2;
    logic [ROB_ID_W-1:0] q1;
    logic [ROB_ID_W-1:0] q2;
    logic [ROB_ID_W-1:0] rd;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   off;
    logic [DATA_W-1:0]   pc;
  } rs_entry_t;

endpackage

// File: rtl/rs_multi_cdb_if.sv
// rs_multi_cdb_if -- bundle between issue stage / CDB / ALU and the station.
//   inst_*    : allocate request from the decoder
//   cdb_*     : packed result broadcasts, channel k at [k*W +: W]
//   exe_*     : dispatch stage toward the ALU (exe_ready comes back)
//   rs_full / rs_count : occupancy status
// master = the surrounding core, slave = the reservation station.
interface rs_multi_cdb_if
  import rs_multi_cdb_pkg::*;
#(
  parameter int RS_ID_W = RS_ID_W_DEF,
  parameter int CDB_N   = CDB_N_DEF
);
  logic                      rs_full;
  logic [RS_ID_W:0]          rs_count;

  logic                      inst_valid;
  logic [OPCODE_W-1:0]       inst_opcode;
  logic [FUNC3_W-1:0]        inst_func3;
  logic                      inst_func1;
  logic                      inst_reg1_valid;
  logic                      inst_reg2_valid;
  logic [DATA_W-1:0]         inst_reg1_data;
  logic [DATA_W-1:0]         inst_reg2_data;
  logic [ROB_ID_W-1:0]       inst_reg1_rob_id;
  logic [ROB_ID_W-1:0]       inst_reg2_rob_id;
  logic [ROB_ID_W-1:0]       inst_rd_rob_id;
  logic [DATA_W-1:0]         inst_imm;
  logic [DATA_W-1:0]         inst_off;
  logic [DATA_W-1:0]         inst_pc;

  logic [CDB_N-1:0]          cdb_valid;
  logic [CDB_N*ROB_ID_W-1:0] cdb_rob_id;
  logic [CDB_N*DATA_W-1:0]   cdb_data;

  logic                      exe_ready;
  logic                      exe_valid;
  logic [OPCODE_W-1:0]       exe_opcode;
  logic [FUNC3_W-1:0]        exe_func3;
  logic                      exe_func1;
  logic [DATA_W-1:0]         exe_data1;
  logic [DATA_W-1:0]         exe_data2;
  logic [DATA_W-1:0]         exe_imm;
  logic [DATA_W-1:0]         exe_off;
  logic [DATA_W-1:0]         exe_pc;
  logic [ROB_ID_W-1:0]       exe_rob_target;

  modport master (
    input  rs_full, rs_count,
    output inst_valid, inst_opcode, inst_func3, inst_func1,
           inst_reg1_valid, inst_reg2_valid, inst_reg1_data, inst_reg2_data,
           inst_reg1_rob_id, inst_reg2_rob_id, inst_rd_rob_id,
           inst_imm, inst_off, inst_pc,
           cdb_valid, cdb_rob_id, cdb_data, exe_ready,
    input  exe_valid, exe_opcode, exe_func3, exe_func1, exe_data1, exe_data2,
           exe_imm, exe_off, exe_pc, exe_rob_target
  );

  modport slave (
    output rs_full, rs_count,
    input  inst_valid, inst_opcode, inst_func3, inst_func1,
           inst_reg1_valid, inst_reg2_valid, inst_reg1_data, inst_reg2_data,
           inst_reg1_rob_id, inst_reg2_rob_id, inst_rd_rob_id,
           inst_imm, inst_off, inst_pc,
           cdb_valid, cdb_rob_id, cdb_data, exe_ready,
    output exe_valid, exe_opcode, exe_func3, exe_func1, exe_data1, exe_data2,
           exe_imm, exe_off, exe_pc, exe_rob_target
  );

endinterface

// File: rtl/rs_age_select.sv
// rs_age_select -- oldest-ready picker.
//   ready : per-entry ready vector
//   older : older[i][j]=1 when entry i was allocated before entry j
//   grant : one-hot grant of the ready entry no other ready entry precedes
//   idx   : binary index of grant
//   any   : at least one entry ready
// The allocation rule keeps the matrix a strict total order among busy
// entries, so at most one grant bit can be set.
module rs_age_select #(
  parameter int RS_SZ   = 8,
  parameter int RS_ID_W = 3
) (
  input  logic [RS_SZ-1:0]            ready,
  input  logic [RS_SZ-1:0][RS_SZ-1:0] older,
  output logic [RS_SZ-1:0]            grant,
  output logic [RS_ID_W-1:0]          idx,
  output logic                        any
);

  genvar i, j;
  for (i = 0; i < RS_SZ; i++) begin : g_lane
    // col[j] = entry j is older than entry i
    logic [RS_SZ-1:0] col;
    for (j = 0; j < RS_SZ; j++) begin : g_col
      assign col[j] = older[j][i];
    end
    assign grant[i] = ready[i] & ~|(ready & col);
  end

  always_comb begin
    idx = '0;
    for (int k = 0; k < RS_SZ; k++)
      if (grant[k]) idx = RS_ID_W'(k);
  end

  assign any = |ready;

endmodule

// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb -- reservation station for the ALU with CDB_N wakeup channels.
//   clk, rst  : clock, asynchronous active-high reset
//   rdy       : global enable, all state frozen while low
//   rollback  : synchronous flush (mispredict)
//   bus       : rs_multi_cdb_if slave -- allocate, CDB snoop, ALU dispatch,
//               rs_full (combinational) and rs_count (registered)
// Operand/tag widths come from rs_multi_cdb_pkg.
module rs_multi_cdb
  import rs_multi_cdb_pkg::*;
#(
  parameter int RS_SZ   = RS_SZ_DEF,
  parameter int RS_ID_W = RS_ID_W_DEF,
  parameter int CDB_N   = CDB_N_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            rollback,
  rs_multi_cdb_if.slave   bus
);

  // {hit, data} of the lowest-index valid channel carrying tag
  function automatic logic [DATA_W:0] cdb_match(
    input logic [ROB_ID_W-1:0]             tag,
    input logic [CDB_N-1:0]                vld,
    input logic [CDB_N-1:0][ROB_ID_W-1:0]  tags,
    input logic [CDB_N-1:0][DATA_W-1:0]    dat
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int k = CDB_N-1; k >= 0; k--)
      if (vld[k] && tags[k] == tag) r = {1'b1, dat[k]};
    return r;
  endfunction

  rs_entry_t                      ent [RS_SZ];
  logic [RS_SZ-1:0]               busy;
  logic [RS_SZ-1:0][RS_SZ-1:0]    older;
  logic [RS_ID_W:0]               count;

  logic [CDB_N-1:0][ROB_ID_W-1:0] cdb_tag;
  logic [CDB_N-1:0][DATA_W-1:0]   cdb_dat;
  assign cdb_tag = bus.cdb_rob_id;
  assign cdb_dat = bus.cdb_data;

  // free slot search over registered busy: a slot freed by this cycle's
  // dispatch only becomes visible next cycle
  logic [RS_ID_W-1:0] alloc_idx;
  logic               have_free;
  logic               alloc;
  always_comb begin
    alloc_idx = '0;
    have_free = 1'b0;
    for (int i = RS_SZ-1; i >= 0; i--)
      if (!busy[i]) begin
        alloc_idx = RS_ID_W'(i);
        have_free = 1'b1;
      end
  end
  assign alloc       = bus.inst_valid & have_free;
  assign bus.rs_full = ~have_free;
  assign bus.rs_count = count;

  // incoming op, with same-cycle CDB bypass on waiting operands
  logic [DATA_W:0] byp1, byp2;
  rs_entry_t       new_ent;
  always_comb begin
    byp1 = cdb_match(bus.inst_reg1_rob_id, bus.cdb_valid, cdb_tag, cdb_dat);
    byp2 = cdb_match(bus.inst_reg2_rob_id, bus.cdb_valid, cdb_tag, cdb_dat);
    new_ent        = '0;
    new_ent.opcode = bus.inst_opcode;
    new_ent.func3  = bus.inst_func3;
    new_ent.func1  = bus.inst_func1;
    new_ent.v1     = bus.inst_reg1_valid | byp1[DATA_W];
    new_ent.v2     = bus.inst_reg2_valid | byp2[DATA_W];
    new_ent.d1     = bus.inst_reg1_valid ? bus.inst_reg1_data : byp1[DATA_W-1:0];
    new_ent.d2     = bus.inst_reg2_valid ? bus.inst_reg2_data : byp2[DATA_W-1:0];
    new_ent.q1     = bus.inst_reg1_rob_id;
    new_ent.q2     = bus.inst_reg2_rob_id;
    new_ent.rd     = bus.inst_rd_rob_id;
    new_ent.imm    = bus.inst_imm;
    new_ent.off    = bus.inst_off;
    new_ent.pc     = bus.inst_pc;
  end

  // per-entry wakeup lookups and readiness (registered operand state only)
  logic [DATA_W:0]  wk1 [RS_SZ];
  logic [DATA_W:0]  wk2 [RS_SZ];
  logic [RS_SZ-1:0] ready;
  always_comb begin
    for (int i = 0; i < RS_SZ; i++) begin
      wk1[i]   = cdb_match(ent[i].q1, bus.cdb_valid, cdb_tag, cdb_dat);
      wk2[i]   = cdb_match(ent[i].q2, bus.cdb_valid, cdb_tag, cdb_dat);
      ready[i] = busy[i] & ent[i].v1 & ent[i].v2;
    end
  end

  logic [RS_SZ-1:0]   grant;
  logic [RS_ID_W-1:0] sel_idx;
  logic               sel_any;
  rs_age_select #(.RS_SZ(RS_SZ), .RS_ID_W(RS_ID_W)) u_sel (
    .ready (ready),
    .older (older),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  logic exe_valid_q;
  logic fire;
  assign fire = (~exe_valid_q | bus.exe_ready) & sel_any;

  // entry payload: only meaningful under busy, so no reset needed
  always_ff @(posedge clk) begin
    if (rdy && !rollback) begin
      for (int i = 0; i < RS_SZ; i++) begin
        if (busy[i] && !ent[i].v1 && wk1[i][DATA_W]) begin
          ent[i].v1 <= 1'b1;
          ent[i].d1 <= wk1[i][DATA_W-1:0];
        end
        if (busy[i] && !ent[i].v2 && wk2[i][DATA_W]) begin
          ent[i].v2 <= 1'b1;
          ent[i].d2 <= wk2[i][DATA_W-1:0];
        end
      end
      if (alloc) ent[alloc_idx] <= new_ent;
    end
  end

  logic [OPCODE_W-1:0] exe_opcode_q;
  logic [FUNC3_W-1:0]  exe_func3_q;
  logic                exe_func1_q;
  logic [DATA_W-1:0]   exe_data1_q, exe_data2_q, exe_imm_q, exe_off_q, exe_pc_q;
  logic [ROB_ID_W-1:0] exe_rob_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= '0;
      older        <= '0;
      count        <= '0;
      exe_valid_q  <= 1'b0;
      exe_opcode_q <= '0;
      exe_func3_q  <= '0;
      exe_func1_q  <= 1'b0;
      exe_data1_q  <= '0;
      exe_data2_q  <= '0;
      exe_imm_q    <= '0;
      exe_off_q    <= '0;
      exe_pc_q     <= '0;
      exe_rob_q    <= '0;
    end else if (rdy) begin
      if (rollback) begin
        busy         <= '0;
        older        <= '0;
        count        <= '0;
        exe_valid_q  <= 1'b0;
        exe_opcode_q <= '0;
        exe_func3_q  <= '0;
        exe_func1_q  <= 1'b0;
        exe_data1_q  <= '0;
        exe_data2_q  <= '0;
        exe_imm_q    <= '0;
        exe_off_q    <= '0;
        exe_pc_q     <= '0;
        exe_rob_q    <= '0;
      end else begin
        if (fire) begin
          exe_valid_q   <= 1'b1;
          exe_opcode_q  <= ent[sel_idx].opcode;
          exe_func3_q   <= ent[sel_idx].func3;
          exe_func1_q   <= ent[sel_idx].func1;
          exe_data1_q   <= ent[sel_idx].d1;
          exe_data2_q   <= ent[sel_idx].d2;
          exe_imm_q     <= ent[sel_idx].imm;
          exe_off_q     <= ent[sel_idx].off;
          exe_pc_q      <= ent[sel_idx].pc;
          exe_rob_q     <= ent[sel_idx].rd;
          busy[sel_idx] <= 1'b0;
        end else if (bus.exe_ready) begin
          exe_valid_q <= 1'b0;
        end
        if (alloc) begin
          busy[alloc_idx] <= 1'b1;
          // every current occupant is older than the newcomer
          for (int j = 0; j < RS_SZ; j++)
            older[j][alloc_idx] <= busy[j];
          older[alloc_idx] <= '0;
        end
        count <= count + (RS_ID_W+1)'(alloc) - (RS_ID_W+1)'(fire);
      end
    end
  end

  assign bus.exe_valid      = exe_valid_q;
  assign bus.exe_opcode     = exe_opcode_q;
  assign bus.exe_func3      = exe_func3_q;
  assign bus.exe_func1      = exe_func1_q;
  assign bus.exe_data1      = exe_data1_q;
  assign bus.exe_data2      = exe_data2_q;
  assign bus.exe_imm        = exe_imm_q;
  assign bus.exe_off        = exe_off_q;
  assign bus.exe_pc         = exe_pc_q;
  assign bus.exe_rob_target = exe_rob_q;

endmodule

// File: tb/tb_rs_multi_cdb.sv
// tb_rs_multi_cdb -- directed scenarios plus randomized traffic, checked
// every negedge against an age-stamp reference model of the station.
module tb_rs_multi_cdb;
  import rs_multi_cdb_pkg::*;

  localparam int RS_SZ   = 8;
  localparam int RS_ID_W = 3;
  localparam int CDB_N   = 2;

  logic clk = 1'b0;
  logic rst, rdy, rollback;
  always #5 clk = ~clk;

  rs_multi_cdb_if #(.RS_ID_W(RS_ID_W), .CDB_N(CDB_N)) bus ();

  rs_multi_cdb #(.RS_SZ(RS_SZ), .RS_ID_W(RS_ID_W), .CDB_N(CDB_N)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit              busy;
    int unsigned     stamp;   // allocation order, smaller = older
    bit              v1, v2;
    logic [31:0]     d1, d2;
    logic [3:0]      q1, q2, rd;
    logic [6:0]      op;
    logic [2:0]      f3;
    logic            f1;
    logic [31:0]     imm, off, pc;
  } ment_t;

  ment_t       m [RS_SZ];
  ment_t       m_exe;
  bit          m_ev;
  int unsigned stamp_ctr;

  function automatic void lookup(input logic [3:0] tag, input logic [CDB_N-1:0] cv,
                                 input logic [CDB_N*4-1:0] ct, input logic [CDB_N*32-1:0] cd,
                                 output bit hit, output logic [31:0] d);
    hit = 0; d = '0;
    for (int k = 0; k < CDB_N; k++)
      if (!hit && cv[k] && ct[k*4 +: 4] == tag) begin
        hit = 1;
        d = cd[k*32 +: 32];
      end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < RS_SZ; i++) m[i].busy = 0;
    m_ev = 0;
    m_exe = '{default: 0};
  endtask

  task automatic model_step();
    int nfree, sel;
    bit fire, h;
    logic [31:0] d;
    ment_t n;
    nfree = -1; sel = -1;
    for (int i = 0; i < RS_SZ; i++)
      if (!m[i].busy && nfree < 0) nfree = i;
    for (int i = 0; i < RS_SZ; i++)
      if (m[i].busy && m[i].v1 && m[i].v2 && (sel < 0 || m[i].stamp < m[sel].stamp)) sel = i;
    fire = (!m_ev || bus.exe_ready) && sel >= 0;
    if (fire) begin
      m_exe = m[sel];
      m_ev = 1;
    end else if (bus.exe_ready) m_ev = 0;
    for (int i = 0; i < RS_SZ; i++) if (m[i].busy) begin
      if (!m[i].v1) begin
        lookup(m[i].q1, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_data, h, d);
        if (h) begin m[i].v1 = 1; m[i].d1 = d; end
      end
      if (!m[i].v2) begin
        lookup(m[i].q2, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_data, h, d);
        if (h) begin m[i].v2 = 1; m[i].d2 = d; end
      end
    end
    if (fire) m[sel].busy = 0;
    if (bus.inst_valid && nfree >= 0) begin
      n.busy = 1; n.stamp = stamp_ctr++;
      n.q1 = bus.inst_reg1_rob_id; n.q2 = bus.inst_reg2_rob_id;
      n.v1 = bus.inst_reg1_valid;  n.d1 = bus.inst_reg1_data;
      n.v2 = bus.inst_reg2_valid;  n.d2 = bus.inst_reg2_data;
      if (!n.v1) begin lookup(n.q1, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_data, h, d);
        if (h) begin n.v1 = 1; n.d1 = d; end end
      if (!n.v2) begin lookup(n.q2, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_data, h, d);
        if (h) begin n.v2 = 1; n.d2 = d; end end
      n.rd = bus.inst_rd_rob_id; n.op = bus.inst_opcode; n.f3 = bus.inst_func3;
      n.f1 = bus.inst_func1; n.imm = bus.inst_imm; n.off = bus.inst_off; n.pc = bus.inst_pc;
      m[nfree] = n;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_clear();
    else if (rdy) begin
      if (rollback) model_clear();
      else model_step();
    end
  end

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < RS_SZ; i++) c += m[i].busy;
    return c;
  endfunction

  bit started = 0;
  always @(negedge clk) if (started && !rst) begin
    chk("rs_count", 64'(bus.rs_count), 64'(m_count()));
    chk("rs_full",  64'(bus.rs_full),  64'(m_count() == RS_SZ));
    chk("exe_valid", 64'(bus.exe_valid), 64'(m_ev));
    if (m_ev) begin
      chk("exe_data1",  64'(bus.exe_data1),      64'(m_exe.d1));
      chk("exe_data2",  64'(bus.exe_data2),      64'(m_exe.d2));
      chk("exe_target", 64'(bus.exe_rob_target), 64'(m_exe.rd));
      chk("exe_op",     64'({bus.exe_opcode, bus.exe_func3, bus.exe_func1}),
                        64'({m_exe.op, m_exe.f3, m_exe.f1}));
      chk("exe_imm_off_pc", {bus.exe_imm, bus.exe_off ^ bus.exe_pc},
                            {m_exe.imm, m_exe.off ^ m_exe.pc});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1; rollback = 0;
    bus.inst_valid = 0; bus.cdb_valid = '0; bus.exe_ready = 1;
  endtask

  task automatic issue(input bit v1, input logic [31:0] d1, input logic [3:0] q1,
                       input bit v2, input logic [31:0] d2, input logic [3:0] q2,
                       input logic [3:0] rd);
    bus.inst_valid = 1;
    bus.inst_opcode = 7'h33; bus.inst_func3 = 3'd0; bus.inst_func1 = 1'b0;
    bus.inst_reg1_valid = v1; bus.inst_reg1_data = d1; bus.inst_reg1_rob_id = q1;
    bus.inst_reg2_valid = v2; bus.inst_reg2_data = d2; bus.inst_reg2_rob_id = q2;
    bus.inst_rd_rob_id = rd;
    bus.inst_imm = 32'h10 + 32'(rd); bus.inst_off = 32'h4; bus.inst_pc = 32'h1000 + 32'(rd);
  endtask

  task automatic cdb(input int ch, input logic [3:0] tag, input logic [31:0] d);
    bus.cdb_valid[ch] = 1'b1;
    bus.cdb_rob_id[ch*4 +: 4] = tag;
    bus.cdb_data[ch*32 +: 32] = d;
  endtask

  initial begin
    rst = 1; idle();
    bus.cdb_rob_id = '0; bus.cdb_data = '0;
    issue(0, 0, 0, 0, 0, 0, 0); bus.inst_valid = 0;
    stamp_ctr = 0;
    tick(); tick();
    rst = 0;
    started = 1;
    chk("reset_exe_valid", 64'(bus.exe_valid), 0);
    chk("reset_count",     64'(bus.rs_count), 0);
    chk("reset_full",      64'(bus.rs_full), 0);
    chk("reset_data1",     64'(bus.exe_data1), 0);

    // ADD 5 + 7 -> tag 3
    issue(1, 5, 0, 1, 7, 0, 3); tick(); bus.inst_valid = 0;
    chk("add_count_alloc", 64'(bus.rs_count), 1);
    tick();
    chk("add_valid",  64'(bus.exe_valid), 1);
    chk("add_data1",  64'(bus.exe_data1), 5);
    chk("add_data2",  64'(bus.exe_data2), 7);
    chk("add_target", 64'(bus.exe_rob_target), 3);
    chk("add_count",  64'(bus.rs_count), 0);

    // wait on tag 6, broadcast 3 cycles later on ch1
    issue(0, 0, 6, 1, 32'h22, 0, 4); tick(); bus.inst_valid = 0;
    tick(); tick(); tick();
    cdb(1, 6, 32'h1234); tick(); bus.cdb_valid = '0;
    chk("wake_not_yet", 64'(bus.exe_valid), 0);
    tick();
    chk("wake_valid",  64'(bus.exe_valid), 1);
    chk("wake_data1",  64'(bus.exe_data1), 32'h1234);
    chk("wake_target", 64'(bus.exe_rob_target), 4);

    // same-cycle bypass on ch0
    issue(0, 0, 9, 1, 32'h33, 0, 5); cdb(0, 9, 32'hAA); tick();
    bus.inst_valid = 0; bus.cdb_valid = '0;
    tick();
    chk("byp_valid", 64'(bus.exe_valid), 1);
    chk("byp_data1", 64'(bus.exe_data1), 32'hAA);

    // fill, then age order
    for (int i = 1; i <= 8; i++) begin
      issue(0, 0, 4'(i), 1, 32'(i * 16), 0, 4'(i)); tick();
    end
    bus.inst_valid = 0;
    chk("fill_full",  64'(bus.rs_full), 1);
    chk("fill_count", 64'(bus.rs_count), 8);
    cdb(0, 8, 32'h800); cdb(1, 1, 32'h100); tick(); bus.cdb_valid = '0;
    tick();
    bus.exe_ready = 0;
    chk("age_first", 64'(bus.exe_rob_target), 1);
    chk("age_data",  64'(bus.exe_data1), 32'h100);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("hold_valid",  64'(bus.exe_valid), 1);
      chk("hold_target", 64'(bus.exe_rob_target), 1);
      chk("hold_count",  64'(bus.rs_count), 7);
    end
    bus.exe_ready = 1; tick();
    chk("age_second", 64'(bus.exe_rob_target), 8);
    chk("age_count",  64'(bus.rs_count), 6);
    cdb(0, 2, 32'h200); tick(); bus.cdb_valid = '0;
    tick();
    chk("third_target", 64'(bus.exe_rob_target), 2);
    chk("five_busy",    64'(bus.rs_count), 5);

    // rollback
    bus.exe_ready = 0; rollback = 1; tick(); rollback = 0;
    chk("rb_valid", 64'(bus.exe_valid), 0);
    chk("rb_count", 64'(bus.rs_count), 0);
    chk("rb_full",  64'(bus.rs_full), 0);

    // asynchronous reset mid-cycle
    bus.exe_ready = 1;
    issue(1, 1, 0, 1, 2, 0, 7); tick();
    bus.exe_ready = 0; issue(0, 0, 3, 1, 2, 0, 8); tick(); bus.inst_valid = 0;
    chk("pre_rst_valid", 64'(bus.exe_valid), 1);
    #3 rst = 1;
    #1;
    chk("arst_valid", 64'(bus.exe_valid), 0);
    chk("arst_count", 64'(bus.rs_count), 0);
    chk("arst_data1", 64'(bus.exe_data1), 0);
    #1 rst = 0;
    idle(); tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom % 8) != 0;
      rollback = ($urandom % 150) == 0;
      bus.exe_ready = ($urandom % 10) < 7;
      issue($urandom % 2, $urandom, 4'($urandom % 8), $urandom % 2, $urandom,
            4'($urandom % 8), 4'($urandom));
      bus.inst_valid = ($urandom % 3) != 0;
      bus.inst_func3 = 3'($urandom); bus.inst_func1 = 1'($urandom);
      bus.inst_imm = $urandom; bus.inst_off = $urandom; bus.inst_pc = $urandom;
      for (int k = 0; k < CDB_N; k++) begin
        bus.cdb_valid[k] = ($urandom % 10) < 4;
        bus.cdb_rob_id[k*4 +: 4] = 4'($urandom % 8);
        bus.cdb_data[k*32 +: 32] = $urandom;
      end
      tick();
    end
    idle(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_multi_cdb.md
Name: rs_multi_cdb

Overview:
Parametrised reservation station for the out-of-order core, between the decoder/issue stage and the ALU.
- Holds up to RS_SZ waiting ALU ops.
- Snoops CDB_N result broadcast channels, with same-cycle forwarding into the entry being allocated.
- Dispatches the oldest ready entry to the ALU through a registered valid/ready output stage with backpressure.
- Supersedes the single-ALU/single-LSB wakeup station: adds depth/channel generality, age-ordered select, issue-time bypass and an occupancy count.

Parameters:
RS_SZ, 8, number of entries (power of two, >=2)
RS_ID_W, 3, log2(RS_SZ)
ROB_ID_W, 4, ROB tag width
DATA_W, 32, operand/data width
CDB_N, 2, number of result broadcast channels

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global enable; when low all state frozen
rollback  in  1  synchronous flush on mispredict
rs_full  out  1  no free entry this cycle (combinational)
rs_count  out  RS_ID_W+1  number of busy entries (registered)
inst_valid  in  1  allocate request
inst_opcode  in  7  opcode
inst_func3  in  3  funct3
inst_func1  in  1  funct7 bit 5
inst_reg1_valid, inst_reg2_valid  in  1 each  operand already available
inst_reg1_data, inst_reg2_data  in  DATA_W each  operand value
inst_reg1_rob_id, inst_reg2_rob_id  in  ROB_ID_W each  producer tag if not valid
inst_rd_rob_id  in  ROB_ID_W  destination tag
inst_imm, inst_off, inst_pc  in  DATA_W each  immediate, branch offset, pc
cdb_valid  in  CDB_N  per-channel broadcast valid
cdb_rob_id  in  CDB_N*ROB_ID_W  packed tags, channel k at [k*ROB_ID_W +: ROB_ID_W]
cdb_data  in  CDB_N*DATA_W  packed results
exe_ready  in  1  ALU accepts exe_* this cycle
exe_valid  out  1  dispatch valid
exe_opcode, exe_func3, exe_func1, exe_data1, exe_data2, exe_imm, exe_off, exe_pc, exe_rob_target  out  widths as inputs  dispatched op

Behaviour:
- rst: all busy=0, age matrix cleared, exe_valid=0, rs_count=0, other exe_* =0. rs_full reads 0 after reset.
- rdy=0: no state changes; inst_valid and CDB ignored. Producer must hold or repeat requests.
- rollback (rdy=1): same clearing as rst, on the clock edge. Allocation, wakeup and dispatch in that cycle are discarded.
- Allocation:
  - When inst_valid & !rs_full, write the lowest-index free entry.
  - Caller must not assert inst_valid while rs_full. If it does, the request is dropped.
  - Entries freed by this cycle's dispatch are not reusable until the next cycle.
- Issue-time bypass: an incoming operand with valid=0 whose tag matches any valid CDB channel this cycle is stored with valid=1 and that channel's data.
- Wakeup: for every busy entry, an invalid operand whose tag matches a valid CDB channel captures the data and sets valid on the edge. If multiple channels match, the lowest channel index wins.
- Readiness: an entry is ready when busy and both operands valid, from registered state only. A woken entry is dispatchable the cycle after wakeup, so wakeup-to-dispatch is 1 cycle.
- Age: RS_SZ x RS_SZ age matrix; older[i][j]=1 means i allocated before j.
  - On allocation of entry n, set older[j][n]=1 for all busy j and older[n][j]=0.
  - Select picks the unique ready entry that no other ready entry is older than.
- Dispatch: output stage fires when (!exe_valid | exe_ready) and a ready entry exists.
  - On the edge, exe_* is loaded, exe_valid=1, and the entry's busy is cleared.
  - If exe_valid & !exe_ready, exe_* is held stable and no select occurs.
  - If exe_ready and no ready entry, exe_valid goes 0 next cycle.
- rs_count: next = count + alloc - dispatch, updated on the edge. rs_full = (no free entry), combinational.
- Tag compare covers the full ROB_ID_W; tag reuse after ROB wrap is safe because the ROB never reissues a tag still pending.

Decomposition:
- Shared package/const header: DATA_W, ROB_ID_W, OPCODE and FUNC3 widths, RS_SZ default, and an rs_entry_t struct (or field macros).
- One sub-module, rs_age_select: takes ready vector + age matrix and returns a one-hot grant and index.

Test Plan:
- Issue ADD with both operands valid (r1=5, r2=7, rd tag 3), exe_ready=1 → exe_valid=1 next cycle with exe_data1=5, exe_data2=7, exe_rob_target=3; rs_count returns to 0.
- Issue op waiting on tag 6, then CDB ch1 {6, 0x1234} 3 cycles later → exe_valid exactly 1 cycle after the broadcast, with exe_data1=0x1234.
- Issue op with tag 9 in the same cycle that CDB ch0 broadcasts {9, 0xAA}, other operand valid → captured via bypass; dispatched 1 cycle later with data 0xAA.
- Fill all 8 entries waiting on tags 1..8 → rs_full=1, rs_count=8. Broadcast tags 8 then 1 together on ch0/ch1 → entry with tag 1 (older) dispatches first.
- Hold exe_ready=0 for 4 cycles with exe_valid=1 → exe_* stable throughout; no second entry leaves; the count is unchanged.
- Assert rollback with 5 busy entries and exe_valid=1 → next cycle exe_valid=0, rs_count=0, rs_full=0. Also assert rst asynchronously mid-cycle → outputs clear without a clock edge.
